// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in/serial-out serializer.
package piso_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  // Bit-index width; a 1-bit word would otherwise give a zero-width counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/piso_serializer_strobe_div.sv
// Bit-period divider: tick fires on the last clk of each bit period while run is high.
module strobe_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] r_div_cnt;
  logic             w_hit;

  assign w_hit = (r_div_cnt == div);
  assign tick  = run & w_hit;

  // Held at zero outside a word so the first period always starts from a clean count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               r_div_cnt <= '0;
    else if (!run || w_hit) r_div_cnt <= '0;
    else                    r_div_cnt <= r_div_cnt + 1'b1;
  end
endmodule

// File: rtl/piso_serializer.sv
// Serializes one WIDTH-bit word into a din/en pair for a downstream flop,
// one bit per (div+1) clk cycles, with abort and a done pulse.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [DIV_W-1:0] div,
  input  logic             msb_first,
  input  logic             abort,
  output logic             sdout,
  output logic             sen,
  output logic             busy,
  output logic             done
);
  localparam int BW = cnt_w(WIDTH);

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_word;
  logic [DIV_W-1:0] r_div;
  logic             r_msb;
  logic [BW-1:0]    r_bit_cnt;

  logic             w_run, w_tick, w_accept, w_last;
  logic [BW-1:0]    w_idx;

  strobe_div #(.DIV_W(DIV_W)) u_strobe (
    .clk  (clk),
    .rst  (rst),
    .run  (w_run),
    .div  (r_div),
    .tick (w_tick)
  );

  assign w_run  = (r_state == SHIFT);
  assign w_last = (r_bit_cnt == BW'(WIDTH-1));
  // The stored word never moves; bit order is just a choice of index.
  assign w_idx  = r_msb ? (BW'(WIDTH-1) - r_bit_cnt) : r_bit_cnt;
  assign sdout  = (r_state == SHIFT) & r_word[w_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    load_ready = 1'b0;
    busy       = 1'b0;
    sen        = 1'b0;
    done       = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        // Gated by rst so ready is low while reset is held.
        load_ready = rst;
        w_accept   = load_valid & rst;
        if (w_accept) w_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (abort) w_next = IDLE;
        else begin
          sen = w_tick;
          if (w_tick && w_last) w_next = FIN;
        end
      end
      FIN: begin
        busy   = 1'b1;
        done   = ~abort;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word    <= '0;
      r_div     <= '0;
      r_msb     <= 1'b0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_word    <= load_data;
      r_div     <= div;
      r_msb     <= msb_first;
      r_bit_cnt <= '0;
    end else if (sen && !w_last) begin
      r_bit_cnt <= r_bit_cnt + BW'(1);
    end
  end
endmodule
